// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// Divider hardware is present only when MDU_DIV_EN is defined.
module mdu #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    output logic        busy,
    output logic [31:0] MDUresult
);
    // state | meaning
    // IDLE  | accepting start, mthi/mtlo
    // BUSY  | counting down latency; HI/LO written as counter hits 1
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [15:0] MULT_LD = 16'(MULT_CYC);
    localparam logic [15:0] DIV_LD  = 16'(DIV_CYC);

    state_t      r_state;
    logic        r_busy;
    logic [15:0] r_cnt;
    logic [31:0] r_hi, r_lo, r_a, r_b;
    logic [3:0]  r_op;

    logic        w_is_mul, w_is_div, w_accept;
    logic [63:0] w_prod_s, w_prod_u;

    assign w_is_mul = (MDUOp == 4'd1) || (MDUOp == 4'd2);
`ifdef MDU_DIV_EN
    assign w_is_div = (MDUOp == 4'd3) || (MDUOp == 4'd4);
`else
    assign w_is_div = 1'b0;
`endif
    assign w_accept = start && !r_busy && (w_is_mul || w_is_div);

    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

`ifdef MDU_DIV_EN
    // Divide on magnitudes, then fix signs; keeps 0x80000000 / -1 well defined.
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag, w_b_den, w_q_mag, w_r_mag, w_quo, w_rem;
    assign w_a_neg = (r_op == 4'd3) && r_a[31];
    assign w_b_neg = (r_op == 4'd3) && r_b[31];
    assign w_a_mag = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_b_mag = w_b_neg ? (32'd0 - r_b) : r_b;
    assign w_b_den = (r_b == 32'd0) ? 32'd1 : w_b_mag;
    assign w_q_mag = w_a_mag / w_b_den;
    assign w_r_mag = w_a_mag % w_b_den;
    assign w_quo   = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= BUSY;
                        r_busy  <= 1'b1;
                        r_cnt   <= w_is_mul ? MULT_LD : DIV_LD;
                        r_a     <= A;
                        r_b     <= B;
                        r_op    <= MDUOp;
                    end else if (MDUOp == 4'd7) begin
                        r_hi <= A;
                    end else if (MDUOp == 4'd8) begin
                        r_lo <= A;
                    end
                end
                BUSY: begin
                    if (r_cnt == 16'd1) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        case (r_op)
                            4'd1: begin
                                r_hi <= w_prod_s[63:32];
                                r_lo <= w_prod_s[31:0];
                            end
                            4'd2: begin
                                r_hi <= w_prod_u[63:32];
                                r_lo <= w_prod_u[31:0];
                            end
`ifdef MDU_DIV_EN
                            4'd3, 4'd4: begin
                                if (r_b != 32'd0) begin
                                    r_lo <= w_quo;
                                    r_hi <= w_rem;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;

    always_comb begin
        MDUresult = 32'd0;
        case (MDUOp)
            4'd5:    MDUresult = r_hi;
            4'd6:    MDUresult = r_lo;
            default: MDUresult = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: arithmetic reference model checked every cycle plus directed literals.
// Divide scenarios follow the MDU_DIV_EN build setting.
module tb_mdu;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [3:0]  MDUOp;
    logic        start;
    logic        busy;
    logic [31:0] MDUresult;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    mdu #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .MDUOp(MDUOp),
        .start(start), .busy(busy), .MDUresult(MDUresult)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: remaining busy cycles plus the result to commit when they run out.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_valid;
    int          m_left = 0;

    always @(posedge clk) begin
        longint sa, sb, q, r;
        logic [63:0] prod;
        if (reset) begin
            m_hi = 0; m_lo = 0; m_left = 0; p_valid = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && p_valid) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (start && (MDUOp == 1 || MDUOp == 2)) begin
            if (MDUOp == 1) prod = 64'(longint'($signed(A)) * longint'($signed(B)));
            else            prod = {32'd0, A} * {32'd0, B};
            p_hi = prod[63:32]; p_lo = prod[31:0]; p_valid = 1; m_left = 5;
        end else if (start && DIV_EN && (MDUOp == 3 || MDUOp == 4)) begin
            if (MDUOp == 3) begin sa = longint'($signed(A)); sb = longint'($signed(B)); end
            else            begin sa = longint'({32'd0, A}); sb = longint'({32'd0, B}); end
            p_valid = (B != 0);
            if (p_valid) begin
                q = sa / sb; r = sa % sb;
                p_lo = q[31:0]; p_hi = r[31:0];
            end
            m_left = 10;
        end else if (MDUOp == 7) begin
            m_hi = A;
        end else if (MDUOp == 8) begin
            m_lo = A;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
            chk("model_result", MDUresult, (MDUOp == 5) ? m_hi : (MDUOp == 6) ? m_lo : 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        MDUOp = op; A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0; MDUOp = 4'd0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic rd(input string nm, input logic [3:0] op, input logic [31:0] exp);
        MDUOp = op; #1;
        chk(nm, MDUresult, exp);
        MDUOp = 4'd0;
    endtask

    task automatic mv(input logic [3:0] op, input logic [31:0] a);
        MDUOp = op; A = a;
        tick();
        MDUOp = 4'd0;
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; MDUOp = 4'd0; A = 0; B = 0;
        tick(); tick();
        reset = 1'b0; cmp_en = 1'b1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        rd("reset_hi", 4'd5, 32'd0);
        rd("reset_lo", 4'd6, 32'd0);

        issue(4'd1, 32'hFFFFFFFE, 32'd3);
        wait_idle(n);
        chk("mult_busy_cycles", n, 32'd5);
        rd("mult_hi", 4'd5, 32'hFFFFFFFF);
        rd("mult_lo", 4'd6, 32'hFFFFFFFA);

        issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle(n);
        rd("multu_hi", 4'd5, 32'hFFFFFFFE);
        rd("multu_lo", 4'd6, 32'h00000001);

        issue(4'd1, 32'h7FFFFFFF, 32'h80000000);
        wait_idle(n);
        rd("mult_big_hi", 4'd5, 32'hC0000000);
        rd("mult_big_lo", 4'd6, 32'h80000000);

        issue(4'd1, 32'd6, 32'd7);
        tick();
        issue(4'd3, 32'd100, 32'd3);
        wait_idle(n);
        chk("overlap_remaining_busy", n, 32'd3);
        rd("overlap_hi", 4'd5, 32'd0);
        rd("overlap_lo", 4'd6, 32'd42);

        issue(4'd9, 32'd1, 32'd1);
        chk("op9_busy", {31'd0, busy}, 32'd0);

        issue(4'd2, 32'd2, 32'd3);
        mv(4'd8, 32'hABCD);
        wait_idle(n);
        rd("mtlo_busy_lo", 4'd6, 32'd6);
        mv(4'd8, 32'hABCD);
        rd("mtlo_lo", 4'd6, 32'hABCD);
        mv(4'd7, 32'h1234);
        rd("mthi_hi", 4'd5, 32'h1234);

`ifdef MDU_DIV_EN
        issue(4'd4, 32'd7, 32'd0);
        wait_idle(n);
        chk("divz_busy_cycles", n, 32'd10);
        rd("divz_hi", 4'd5, 32'h1234);
        rd("divz_lo", 4'd6, 32'hABCD);

        issue(4'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        chk("div_busy_cycles", n, 32'd10);
        rd("div_lo", 4'd6, 32'hFFFFFFFD);
        rd("div_hi", 4'd5, 32'hFFFFFFFF);

        issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        rd("div_ovf_lo", 4'd6, 32'h80000000);
        rd("div_ovf_hi", 4'd5, 32'h00000000);

        issue(4'd4, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        rd("divu_lo", 4'd6, 32'h7FFFFFFC);
        rd("divu_hi", 4'd5, 32'h00000001);

        issue(4'd3, 32'd100, 32'd7);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("div_reset_busy", {31'd0, busy}, 32'd0);
        rd("div_reset_hi", 4'd5, 32'd0);
        rd("div_reset_lo", 4'd6, 32'd0);
        mv(4'd7, 32'h1234);
        mv(4'd8, 32'hABCD);
`else
        issue(4'd3, 32'd100, 32'd7);
        chk("nodiv_busy", {31'd0, busy}, 32'd0);
        tick(); tick();
        rd("nodiv_hi", 4'd5, 32'h1234);
        rd("nodiv_lo", 4'd6, 32'hABCD);
`endif

        issue(4'd1, 32'd5, 32'd5);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mult_reset_busy", {31'd0, busy}, 32'd0);
        rd("mult_reset_hi", 4'd5, 32'd0);
        rd("mult_reset_lo", 4'd6, 32'd0);
        repeat (7) tick();
        rd("mult_reset_discard_lo", 4'd6, 32'd0);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
